bsg_nonsynth_axil_mem: RTL and testbench

// - AXI4-Lite slave memory model for cosim benches; next generation of the AXI-Lite-to-DPI responder.
// - Serves HP-port style AXI-Lite masters from an internal word array, so no DPI round-trip is needed.
// - Adds parametrised width and depth, multiple outstanding transactions per channel, fixed response latency, write strobes and DECERR on out-of-range addresses.

---
 rtl/bsg_nonsynth_axil_mem.sv | 157 +++++++++++++++
 tb/tb_bsg_nonsynth_axil_mem.sv | 315 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/bsg_nonsynth_axil_mem.sv
// AXI4-Lite slave memory model backed by an internal word array.
// Per-channel in-order response queues with a fixed latency; out-of-range accesses return DECERR.

module bsg_nonsynth_axil_mem_rsp_q
  #(parameter int unsigned width_p   = 2
  , parameter int unsigned depth_p   = 4
  , parameter int unsigned latency_p = 2)
  (input  logic               clk_i
  , input  logic               reset_i
  , input  logic               enq_i
  , input  logic [width_p-1:0] data_i
  , output logic               ready_o
  , output logic               valid_o
  , output logic [width_p-1:0] data_o
  , input  logic               yumi_i);

  localparam int unsigned ptr_w = (depth_p > 1) ? $clog2(depth_p) : 1;
  localparam int unsigned cnt_w = $clog2(depth_p + 1);
  localparam int unsigned lat_w = $clog2(latency_p + 1);

  logic [width_p-1:0] data_r [depth_p];
  logic [lat_w-1:0]   cd_r   [depth_p];
  logic [ptr_w-1:0]   head_r, tail_r;
  logic [cnt_w-1:0]   count_r;
  logic               deq;

  function automatic logic [ptr_w-1:0] next_ptr(input logic [ptr_w-1:0] p);
    return (p == ptr_w'(depth_p - 1)) ? '0 : p + ptr_w'(1);
  endfunction

  // ready uses the pre-dequeue count, so a full queue never accepts even while draining
  assign ready_o = (count_r < cnt_w'(depth_p));
  assign valid_o = (count_r != '0) && (cd_r[head_r] == '0);
  assign data_o  = valid_o ? data_r[head_r] : '0;
  assign deq     = valid_o & yumi_i;

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      head_r  <= '0;
      tail_r  <= '0;
      count_r <= '0;
      for (int i = 0; i < int'(depth_p); i++) begin
        data_r[i] <= '0;
        cd_r[i]   <= '0;
      end
    end else begin
      for (int i = 0; i < int'(depth_p); i++) begin
        if (enq_i && (tail_r == ptr_w'(i))) begin
          data_r[i] <= data_i;
          cd_r[i]   <= lat_w'(latency_p);
        end else if (cd_r[i] != '0) begin
          cd_r[i] <= cd_r[i] - lat_w'(1);
        end
      end
      if (enq_i) tail_r <= next_ptr(tail_r);
      if (deq)   head_r <= next_ptr(head_r);
      if (enq_i && !deq)      count_r <= count_r + cnt_w'(1);
      else if (!enq_i && deq) count_r <= count_r - cnt_w'(1);
    end
  end

endmodule

module bsg_nonsynth_axil_mem
  #(parameter int unsigned addr_width_p  = 32
  , parameter int unsigned data_width_p  = 32
  , parameter int unsigned els_p         = 1024
  , parameter int unsigned outstanding_p = 4
  , parameter int unsigned rd_latency_p  = 2
  , parameter int unsigned wr_latency_p  = 2)
  (input  logic                      clk_i
  , input  logic                      reset_i
  , input  logic [addr_width_p-1:0]   awaddr_i
  , input  logic [2:0]                awprot_i
  , input  logic                      awvalid_i
  , output logic                      awready_o
  , input  logic [data_width_p-1:0]   wdata_i
  , input  logic [data_width_p/8-1:0] wstrb_i
  , input  logic                      wvalid_i
  , output logic                      wready_o
  , output logic [1:0]                bresp_o
  , output logic                      bvalid_o
  , input  logic                      bready_i
  , input  logic [addr_width_p-1:0]   araddr_i
  , input  logic [2:0]                arprot_i
  , input  logic                      arvalid_i
  , output logic                      arready_o
  , output logic [data_width_p-1:0]   rdata_o
  , output logic [1:0]                rresp_o
  , output logic                      rvalid_o
  , input  logic                      rready_i);

  localparam int unsigned strb_w = data_width_p / 8;
  localparam int unsigned off_w  = $clog2(strb_w);
  localparam int unsigned idx_w  = (els_p > 1) ? $clog2(els_p) : 1;
  localparam logic [1:0]  resp_okay   = 2'b00;
  localparam logic [1:0]  resp_decerr = 2'b11;

  // contents survive reset; zero only at time 0
  logic [data_width_p-1:0] mem_r [els_p] = '{default: '0};

  logic [addr_width_p-1:0] ar_idx, aw_idx;
  logic                    ar_in_range, aw_in_range;
  logic                    rd_rdy, wr_rdy, ar_fire, aw_fire;
  logic [data_width_p-1:0] rd_word;
  logic                    unused_prot;

  assign unused_prot = ^{awprot_i, arprot_i};

  assign ar_idx      = araddr_i >> off_w;
  assign aw_idx      = awaddr_i >> off_w;
  assign ar_in_range = (ar_idx < addr_width_p'(els_p));
  assign aw_in_range = (aw_idx < addr_width_p'(els_p));

  assign arready_o = rd_rdy & ~reset_i;
  assign ar_fire   = arvalid_i & arready_o;
  // AW and W only ever accept together
  assign awready_o = wr_rdy & awvalid_i & wvalid_i & ~reset_i;
  assign wready_o  = awready_o;
  assign aw_fire   = awready_o;

  // read sees the array before any same-cycle write lands
  assign rd_word = ar_in_range ? mem_r[ar_idx[idx_w-1:0]] : '0;

  always_ff @(posedge clk_i) begin
    if (aw_fire && aw_in_range) begin
      for (int b = 0; b < int'(strb_w); b++) begin
        if (wstrb_i[b]) mem_r[aw_idx[idx_w-1:0]][8*b +: 8] <= wdata_i[8*b +: 8];
      end
    end
  end

  bsg_nonsynth_axil_mem_rsp_q
    #(.width_p(data_width_p + 2), .depth_p(outstanding_p), .latency_p(rd_latency_p))
  rd_q
    (.clk_i   (clk_i)
    ,.reset_i (reset_i)
    ,.enq_i   (ar_fire)
    ,.data_i  ({rd_word, ar_in_range ? resp_okay : resp_decerr})
    ,.ready_o (rd_rdy)
    ,.valid_o (rvalid_o)
    ,.data_o  ({rdata_o, rresp_o})
    ,.yumi_i  (rready_i));

  bsg_nonsynth_axil_mem_rsp_q
    #(.width_p(2), .depth_p(outstanding_p), .latency_p(wr_latency_p))
  wr_q
    (.clk_i   (clk_i)
    ,.reset_i (reset_i)
    ,.enq_i   (aw_fire)
    ,.data_i  (aw_in_range ? resp_okay : resp_decerr)
    ,.ready_o (wr_rdy)
    ,.valid_o (bvalid_o)
    ,.data_o  (bresp_o)
    ,.yumi_i  (bready_i));

endmodule

// File: tb/tb_bsg_nonsynth_axil_mem.sv
// Bench for bsg_nonsynth_axil_mem: directed scenarios plus random traffic,
// checked by a negedge monitor against a word-array model and response queues.

module tb_bsg_nonsynth_axil_mem;

  localparam int unsigned AW  = 32;
  localparam int unsigned DW  = 32;
  localparam int unsigned ELS = 64;
  localparam int unsigned OUT = 4;
  localparam int unsigned RL  = 2;
  localparam int unsigned WL  = 3;

  logic          clk = 1'b0;
  logic          reset = 1'b0;
  logic [AW-1:0] awaddr = '0, araddr = '0;
  logic [2:0]    awprot = '0, arprot = '0;
  logic          awvalid = 1'b0, wvalid = 1'b0, arvalid = 1'b0;
  logic          bready = 1'b1, rready = 1'b1;
  logic [DW-1:0] wdata = '0;
  logic [3:0]    wstrb = '0;
  logic          awready, wready, bvalid, arready, rvalid;
  logic [1:0]    bresp, rresp;
  logic [DW-1:0] rdata;

  bsg_nonsynth_axil_mem #(
    .addr_width_p(AW), .data_width_p(DW), .els_p(ELS), .outstanding_p(OUT),
    .rd_latency_p(RL), .wr_latency_p(WL)
  ) dut (
    .clk_i(clk), .reset_i(reset),
    .awaddr_i(awaddr), .awprot_i(awprot), .awvalid_i(awvalid), .awready_o(awready),
    .wdata_i(wdata), .wstrb_i(wstrb), .wvalid_i(wvalid), .wready_o(wready),
    .bresp_o(bresp), .bvalid_o(bvalid), .bready_i(bready),
    .araddr_i(araddr), .arprot_i(arprot), .arvalid_i(arvalid), .arready_o(arready),
    .rdata_o(rdata), .rresp_o(rresp), .rvalid_o(rvalid), .rready_i(rready)
  );

  always #5 clk = ~clk;

  int unsigned cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [31:0] data;
    logic [1:0]  resp;
    int unsigned acc;
  } rsp_t;

  rsp_t        rd_q[$];
  rsp_t        wr_q[$];
  logic [31:0] mdl [ELS];
  int          checks = 0;
  int          errors = 0;

  function automatic void chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endfunction

  // monitor: ready/valid against queue occupancy, payload against queue head, then record accepts
  logic        exp_rv, exp_bv;
  rsp_t        ent;
  int unsigned widx;
  always @(negedge clk) begin
    if (reset) begin
      rd_q.delete();
      wr_q.delete();
    end else begin
      chk("arready", 64'(arready), 64'(rd_q.size() < int'(OUT)));
      chk("awready", 64'(awready), 64'(awvalid && wvalid && (wr_q.size() < int'(OUT))));
      chk("wready",  64'(wready),  64'(awvalid && wvalid && (wr_q.size() < int'(OUT))));
      exp_rv = 1'b0;
      if (rd_q.size() != 0) exp_rv = (cyc >= rd_q[0].acc + RL);
      chk("rvalid", 64'(rvalid), 64'(exp_rv));
      if (rvalid && exp_rv) begin
        chk("rdata", 64'(rdata), 64'(rd_q[0].data));
        chk("rresp", 64'(rresp), 64'(rd_q[0].resp));
        if (rready) void'(rd_q.pop_front());
      end
      exp_bv = 1'b0;
      if (wr_q.size() != 0) exp_bv = (cyc >= wr_q[0].acc + WL);
      chk("bvalid", 64'(bvalid), 64'(exp_bv));
      if (bvalid && exp_bv) begin
        chk("bresp", 64'(bresp), 64'(wr_q[0].resp));
        if (bready) void'(wr_q.pop_front());
      end
      // read is recorded before the write so a same-word pair returns old data
      if (arvalid && arready) begin
        widx = araddr >> 2;
        ent.acc = cyc + 1;
        if (widx < ELS) begin ent.data = mdl[widx]; ent.resp = 2'd0; end
        else begin ent.data = '0; ent.resp = 2'd3; end
        rd_q.push_back(ent);
      end
      if (awvalid && wvalid && awready) begin
        widx = awaddr >> 2;
        ent.acc = cyc + 1;
        ent.data = '0;
        if (widx < ELS) begin
          for (int b = 0; b < 4; b++)
            if (wstrb[b]) mdl[widx][8*b +: 8] = wdata[8*b +: 8];
          ent.resp = 2'd0;
        end else ent.resp = 2'd3;
        wr_q.push_back(ent);
      end
    end
  end

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic send_ar(input logic [31:0] a, output int unsigned acc);
    int n = 0;
    acc = 0;
    arvalid = 1'b1; araddr = a;
    while (1) begin
      @(negedge clk);
      if (arready) begin acc = cyc + 1; break; end
      if (++n > 100) begin checks++; errors++; $display("FAIL ar_timeout: no accept for %0h", a); break; end
    end
    tick();
    arvalid = 1'b0;
  endtask

  task automatic send_w(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s);
    int n = 0;
    awvalid = 1'b1; wvalid = 1'b1; awaddr = a; wdata = d; wstrb = s;
    while (1) begin
      @(negedge clk);
      if (awready) break;
      if (++n > 100) begin checks++; errors++; $display("FAIL aw_timeout: no accept for %0h", a); break; end
    end
    tick();
    awvalid = 1'b0; wvalid = 1'b0;
  endtask

  task automatic wait_r(output logic [31:0] d, output logic [1:0] r, output int unsigned seen);
    int n = 0;
    d = '0; r = '0; seen = 0;
    while (1) begin
      @(negedge clk);
      if (rvalid) begin d = rdata; r = rresp; seen = cyc; break; end
      if (++n > 100) begin checks++; errors++; $display("FAIL r_timeout: rvalid never rose"); break; end
    end
    tick();
  endtask

  task automatic wait_b(output logic [1:0] r);
    int n = 0;
    r = '0;
    while (1) begin
      @(negedge clk);
      if (bvalid) begin r = bresp; break; end
      if (++n > 100) begin checks++; errors++; $display("FAIL b_timeout: bvalid never rose"); break; end
    end
    tick();
  endtask

  task automatic drain();
    int n = 0;
    while (((rd_q.size() != 0) || (wr_q.size() != 0)) && (n < 200)) begin tick(); n++; end
    chk("drain_left", 64'(rd_q.size() + wr_q.size()), 64'(0));
  endtask

  function automatic logic [31:0] rand_addr();
    int unsigned r = $urandom_range(0, 9);
    if (r == 0) return $urandom;
    if (r < 4)  return 32'($urandom_range(0, 7) * 4 + $urandom_range(0, 3));
    return 32'($urandom_range(0, ELS + 3) * 4 + $urandom_range(0, 3));
  endfunction

  logic [31:0] d;
  logic [1:0]  r;
  int unsigned acc, seen;
  logic        ar_fired = 1'b0, aw_fired = 1'b0;

  initial begin
    for (int i = 0; i < int'(ELS); i++) mdl[i] = '0;
    #1 reset = 1'b1;
    repeat (3) tick();
    chk("rst_arready", 64'(arready), 64'(0));
    chk("rst_awready", 64'(awready), 64'(0));
    chk("rst_rvalid",  64'(rvalid),  64'(0));
    chk("rst_bvalid",  64'(bvalid),  64'(0));
    chk("rst_rdata",   64'(rdata),   64'(0));
    chk("rst_resp",    64'({rresp, bresp}), 64'(0));
    reset = 1'b0;
    tick();

    // full-word write then read with latency measurement
    send_w(32'h10, 32'hDEADBEEF, 4'hF);
    wait_b(r);
    chk("t1_bresp", 64'(r), 64'(0));
    send_ar(32'h10, acc);
    wait_r(d, r, seen);
    chk("t1_rdata", 64'(d), 64'hDEADBEEF);
    chk("t1_latency", 64'(seen - acc), 64'(RL));

    // byte strobes merge into existing word
    send_w(32'h20, 32'h11223344, 4'hF);
    wait_b(r);
    send_w(32'h20, 32'hAABBCCDD, 4'h5);
    wait_b(r);
    send_ar(32'h20, acc);
    wait_r(d, r, seen);
    chk("t2_rdata", 64'(d), 64'h11BB33DD);

    // fill read queue, fifth AR waits for one handshake
    rready = 1'b0;
    for (int i = 0; i < int'(OUT); i++) send_ar(32'(i * 4), acc);
    arvalid = 1'b1; araddr = 32'h10;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      chk("t3_full_arready", 64'(arready), 64'(0));
      tick();
    end
    rready = 1'b1;
    @(negedge clk);
    chk("t3_deq_arready", 64'(arready), 64'(0));
    chk("t3_deq_rvalid", 64'(rvalid), 64'(1));
    tick();
    rready = 1'b0;
    @(negedge clk);
    chk("t3_after_arready", 64'(arready), 64'(1));
    tick();
    arvalid = 1'b0;
    rready = 1'b1;
    drain();

    // out-of-range read and write
    send_ar(ELS * 4, acc);
    wait_r(d, r, seen);
    chk("t4_rresp", 64'(r), 64'(3));
    chk("t4_rdata", 64'(d), 64'(0));
    send_w(ELS * 4, 32'hFFFFFFFF, 4'hF);
    wait_b(r);
    chk("t4_bresp", 64'(r), 64'(3));
    send_ar(32'h0, acc);
    wait_r(d, r, seen);
    chk("t4_word0", 64'(d), 64'(0));

    // AW alone never accepts
    awvalid = 1'b1; awaddr = 32'h30; wvalid = 1'b0;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      chk("t5_awready_alone", 64'({awready, wready}), 64'(0));
      tick();
    end
    wvalid = 1'b1; wdata = 32'hCAFEF00D; wstrb = 4'hF;
    @(negedge clk);
    chk("t5_both_ready", 64'({awready, wready}), 64'(3));
    tick();
    awvalid = 1'b0; wvalid = 1'b0;
    wait_b(r);

    // reset with reads queued
    rready = 1'b0;
    send_ar(32'h10, acc);
    send_ar(32'h20, acc);
    repeat (3) tick();
    reset = 1'b1;
    #1;
    chk("t6_rvalid_in_reset", 64'(rvalid), 64'(0));
    chk("t6_rdata_in_reset", 64'(rdata), 64'(0));
    repeat (2) tick();
    reset = 1'b0;
    rready = 1'b1;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      chk("t6_no_spurious", 64'(rvalid), 64'(0));
      tick();
    end
    send_ar(32'h10, acc);
    wait_r(d, r, seen);
    chk("t6_kept_data", 64'(d), 64'hDEADBEEF);

    // random concurrent traffic with random back-pressure
    for (int i = 0; i < 3000; i++) begin
      @(posedge clk); #1;
      if (!arvalid || ar_fired) begin
        arvalid = 1'($urandom_range(0, 1));
        araddr  = rand_addr();
      end
      if (!awvalid || aw_fired) begin
        awvalid = 1'($urandom_range(0, 1));
        wvalid  = awvalid;
        awaddr  = rand_addr();
        wdata   = $urandom;
        wstrb   = 4'($urandom_range(0, 15));
      end
      rready = ($urandom_range(0, 3) != 0);
      bready = ($urandom_range(0, 3) != 0);
      @(negedge clk);
      ar_fired = arvalid && arready;
      aw_fired = awvalid && wvalid && awready;
    end
    @(posedge clk); #1;
    arvalid = 1'b0; awvalid = 1'b0; wvalid = 1'b0;
    rready = 1'b1; bready = 1'b1;
    drain();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

endmodule
